// File: rtl/shake_pkg.sv
// shake_pkg: shared types and constants for the SHAKE permutation scheduler.
//   sched_state_t : scheduler FSM states
//   KECCAK_ROUNDS : rounds in one Keccak-f[1600] permutation
package shake_pkg;

    localparam int KECCAK_ROUNDS = 24;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROUND    = 2'd1,
        WAIT_BLK = 2'd2,
        DONE     = 2'd3
    } sched_state_t;

endpackage

// File: rtl/shake_round_cnt.sv
// shake_round_cnt: round index counter for one permutation.
// Counts 0..NUM_ROUNDS-1 while i_en is high and wraps back to 0 after the
// last round, so the next permutation always starts from round 0.
//   clk    : clock, rising edge
//   rst    : synchronous reset, active-low
//   i_clr  : force index to 0 (priority over i_en)
//   i_en   : advance one round
//   o_idx  : current round index
//   o_last : index is NUM_ROUNDS-1
module shake_round_cnt #(
    parameter int NUM_ROUNDS = 24,
    parameter int CNT_WIDTH  = $clog2(NUM_ROUNDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic [CNT_WIDTH-1:0] o_idx,
    output logic                 o_last
);

    logic [CNT_WIDTH-1:0] r_idx;
    logic                 w_last;

    assign w_last = (r_idx == CNT_WIDTH'(NUM_ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= w_last ? '0 : r_idx + CNT_WIDTH'(1);
        end
    end

    assign o_idx  = r_idx;
    assign o_last = w_last;

endmodule

// File: rtl/shake_perm_sched.sv
// shake_perm_sched: sequences Keccak-f[1600] rounds for a SHAKE run.
// Runs n_perm permutations back to back, pausing between them in WAIT_BLK
// until the absorb/squeeze datapath signals blk_valid.
// Optional feature macro: SHAKE_SCHED_STALL_EN adds the stall port, which
// freezes the round sequence while in ROUND.
//   clk, rst         : clock; synchronous active-low reset
//   start, n_perm    : begin a run of max(n_perm,1) permutations (IDLE only)
//   abort            : cancel the run, return to IDLE without pulses
//   blk_valid        : next rate block ready (accepted while blk_req=1)
//   stall            : freeze rounds (only with SHAKE_SCHED_STALL_EN)
//   busy             : run in progress
//   round_en         : apply one round this cycle
//   round_idx        : round-constant index
//   round_first/last : first / last round of a permutation
//   blk_req          : waiting for the next block
//   perm_done        : pulse after each permutation's last round
//   perm_cnt         : permutations completed in this run
//   done             : pulse when the run completes
module shake_perm_sched
    import shake_pkg::*;
#(
    parameter int NUM_ROUNDS = KECCAK_ROUNDS,
    parameter int CNT_WIDTH  = $clog2(NUM_ROUNDS),
    parameter int PERM_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PERM_WIDTH-1:0] n_perm,
    input  logic                  abort,
    input  logic                  blk_valid,
`ifdef SHAKE_SCHED_STALL_EN
    input  logic                  stall,
`endif
    output logic                  busy,
    output logic                  round_en,
    output logic [CNT_WIDTH-1:0]  round_idx,
    output logic                  round_first,
    output logic                  round_last,
    output logic                  blk_req,
    output logic                  perm_done,
    output logic [PERM_WIDTH-1:0] perm_cnt,
    output logic                  done
);

    sched_state_t          r_state;
    sched_state_t          w_next_state;
    logic [PERM_WIDTH-1:0] r_n_perm;
    logic [PERM_WIDTH-1:0] r_perm_cnt;
    logic                  r_perm_done;

    logic                  w_stall;
    logic                  w_adv;
    logic                  w_cnt_last;
    logic                  w_cnt_clr;
    logic                  w_start_acc;
    logic                  w_final;
    logic [CNT_WIDTH-1:0]  w_idx;

`ifdef SHAKE_SCHED_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // A round is actually applied only in ROUND and when not frozen.
    assign w_adv       = (r_state == ROUND) && !w_stall;
    assign w_start_acc = (r_state == IDLE) && start && !abort;
    assign w_cnt_clr   = abort || w_start_acc;

    // The permutation finishing now is the last one of the run.
    assign w_final = (({1'b0, r_perm_cnt} + (PERM_WIDTH + 1)'(1)) == {1'b0, r_n_perm});

    shake_round_cnt #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_round_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_adv),
        .o_idx  (w_idx),
        .o_last (w_cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != IDLE);
        round_en     = w_adv;
        round_idx    = w_idx;
        round_first  = w_adv && (w_idx == '0);
        round_last   = w_adv && w_cnt_last;
        blk_req      = (r_state == WAIT_BLK);
        perm_done    = r_perm_done;
        perm_cnt     = r_perm_cnt;
        // An abort landing in the DONE cycle suppresses the completion pulse.
        done         = (r_state == DONE) && !abort;

        case (r_state)
            IDLE: begin
                if (start) w_next_state = ROUND;
            end
            ROUND: begin
                if (w_adv && w_cnt_last) w_next_state = w_final ? DONE : WAIT_BLK;
            end
            WAIT_BLK: begin
                if (blk_valid) w_next_state = ROUND;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (abort) w_next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_n_perm    <= PERM_WIDTH'(1);
            r_perm_cnt  <= '0;
            r_perm_done <= 1'b0;
        end else begin
            r_perm_done <= w_adv && w_cnt_last && !abort;
            if (abort) begin
                r_perm_cnt <= '0;
            end else if (w_start_acc) begin
                r_perm_cnt <= '0;
                r_n_perm   <= (n_perm == '0) ? PERM_WIDTH'(1) : n_perm;
            end else if (w_adv && w_cnt_last && (r_perm_cnt != '1)) begin
                // Saturating: the count must never wrap back to zero.
                r_perm_cnt <= r_perm_cnt + PERM_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_shake_perm_sched.sv
// tb_shake_perm_sched: self-checking bench for shake_perm_sched.
// The expected trace of every run is generated cycle by cycle from the
// run description (permutation count, block delays, abort/reset point,
// stall window), then replayed against the DUT.
module tb_shake_perm_sched;

    localparam int R = 24;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] n_perm;
    logic        abort;
    logic        blk_valid;
    logic        stall;
    logic        busy;
    logic        round_en;
    logic [4:0]  round_idx;
    logic        round_first;
    logic        round_last;
    logic        blk_req;
    logic        perm_done;
    logic [15:0] perm_cnt;
    logic        done;

    shake_perm_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .n_perm      (n_perm),
        .abort       (abort),
        .blk_valid   (blk_valid),
`ifdef SHAKE_SCHED_STALL_EN
        .stall       (stall),
`endif
        .busy        (busy),
        .round_en    (round_en),
        .round_idx   (round_idx),
        .round_first (round_first),
        .round_last  (round_last),
        .blk_req     (blk_req),
        .perm_done   (perm_done),
        .perm_cnt    (perm_cnt),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        abort;
        logic        blkv;
        logic        stall;
        logic [15:0] nperm;
        logic        mark;
        logic [27:0] exp;
    } cyc_t;

    cyc_t        q[$];
    logic [15:0] m_pcnt;
    int          gap_d[8];
    int          n_chk;
    int          n_fail;
    int          cyc;
    int          t_start;
    int          t_done;

    // {busy, round_en, idx, first, last, blk_req, perm_done, perm_cnt, done}
    function automatic logic [27:0] pack(input logic b, input logic r, input logic [4:0] ix,
                                         input logic f, input logic l, input logic br,
                                         input logic pd, input logic [15:0] pc, input logic dn);
        return {b, r, ix, f, l, br, pd, pc, dn};
    endfunction

    function automatic cyc_t blank();
        cyc_t c;
        c.rst_n = 1'b1;
        c.start = 1'b0;
        c.abort = 1'b0;
        c.blkv  = 1'b0;
        c.stall = 1'b0;
        c.nperm = 16'd0;
        c.mark  = 1'b0;
        c.exp   = pack(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, m_pcnt, 1'b0);
        return c;
    endfunction

    task automatic chk(input int act, input int exp, input string name);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_idle(input int cnt, input bit noise);
        cyc_t c;
        for (int i = 0; i < cnt; i++) begin
            c = blank();
            if (noise) begin
                c.blkv  = 1'($urandom_range(0, 1));
                c.abort = ($urandom_range(0, 4) == 0);
`ifdef SHAKE_SCHED_STALL_EN
                c.stall = 1'($urandom_range(0, 1));
`endif
            end
            q.push_back(c);
            if (c.abort) m_pcnt = 16'd0;
        end
    endtask

    // Expected trace of one run: start cycle, n permutations of R rounds,
    // gap_d[p]+1 block-wait cycles between permutations, one DONE cycle.
    task automatic build_run(input int n_req, input int kill_at, input bit kill_rst,
                             input int st_p, input int st_k, input int st_len, input bit noise);
        cyc_t c;
        cyc_t run[$];
        int   n;
        n = (n_req == 0) ? 1 : n_req;
        c = blank();
        c.start = 1'b1;
        c.nperm = 16'(n_req);
        c.mark  = 1'b1;
        if (noise) c.blkv = 1'($urandom_range(0, 1));
        q.push_back(c);
        for (int p = 1; p <= n; p++) begin
            for (int k = 0; k < R; k++) begin
                if (st_len > 0 && p == st_p && k == st_k) begin
                    for (int s = 0; s < st_len; s++) begin
                        c = blank();
                        c.stall = 1'b1;
                        c.exp = pack(1'b1, 1'b0, 5'(k), 1'b0, 1'b0, 1'b0, 1'b0, 16'(p - 1), 1'b0);
                        run.push_back(c);
                    end
                end
                c = blank();
                c.exp = pack(1'b1, 1'b1, 5'(k), (k == 0), (k == R - 1), 1'b0, 1'b0, 16'(p - 1), 1'b0);
                if (noise) begin
                    c.blkv  = 1'($urandom_range(0, 1));
                    c.start = ($urandom_range(0, 7) == 0);
                    c.nperm = 16'($urandom_range(0, 9));
                end
                run.push_back(c);
            end
            if (p < n) begin
                for (int j = 0; j <= gap_d[p]; j++) begin
                    c = blank();
                    c.blkv = (j == gap_d[p]);
                    c.exp = pack(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, (j == 0), 16'(p), 1'b0);
                    if (noise) begin
                        c.start = 1'($urandom_range(0, 1));
`ifdef SHAKE_SCHED_STALL_EN
                        c.stall = 1'($urandom_range(0, 1));
`endif
                    end
                    run.push_back(c);
                end
            end else begin
                c = blank();
                c.exp = pack(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'(n), 1'b1);
                if (noise) c.start = 1'($urandom_range(0, 1));
                run.push_back(c);
            end
        end
        m_pcnt = 16'(n);
        if (kill_at >= 0 && kill_at < run.size() - 1) begin
            while (run.size() > kill_at + 1) c = run.pop_back();
            c = run[kill_at];
            if (kill_rst) c.rst_n = 1'b0;
            else          c.abort = 1'b1;
            run[kill_at] = c;
            m_pcnt = 16'd0;
        end
        foreach (run[i]) q.push_back(run[i]);
        push_idle(2, noise);
    endtask

    task automatic run_queue();
        cyc_t        c;
        logic [27:0] act;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            rst       = c.rst_n;
            start     = c.start;
            abort     = c.abort;
            blk_valid = c.blkv;
            n_perm    = c.nperm;
            stall     = c.stall;
            @(negedge clk);
            cyc++;
            if (c.mark) t_start = cyc;
            if (done === 1'b1) t_done = cyc;
            act = pack(busy, round_en, round_idx, round_first, round_last, blk_req,
                       perm_done, perm_cnt, done);
            n_chk++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL cycle%0d outputs {busy,en,idx,first,last,req,pdone,cnt,done}: got %h expected %h",
                         cyc, act, c.exp);
            end
        end
    endtask

    initial begin
        cyc_t c;
        int   nreq;
        int   nbr;
        clk = 1'b0; rst = 1'b0; start = 1'b0; abort = 1'b0;
        blk_valid = 1'b0; n_perm = 16'd0; stall = 1'b0;
        n_chk = 0; n_fail = 0; cyc = 0; t_start = 0; t_done = 0;
        m_pcnt = 16'd0;
        for (int i = 0; i < 8; i++) gap_d[i] = 0;
        repeat (2) @(posedge clk);

        c = blank();
        c.rst_n = 1'b0;
        q.push_back(c);
        q.push_back(c);
        run_queue();

        build_run(1, -1, 1'b0, 0, 0, 0, 1'b0);
        chk(q.size(), 28, "model_n1_len");
        run_queue();
        chk(t_done - t_start, 25, "n1_done_latency");

        build_run(3, -1, 1'b0, 0, 0, 0, 1'b1);
        run_queue();
        chk(t_done - t_start, 3 * R + 2 + 1, "n3_done_latency");

        gap_d[1] = 5;
        build_run(2, -1, 1'b0, 0, 0, 0, 1'b0);
        nbr = 0;
        foreach (q[i]) nbr += int'(q[i].exp[18]);
        chk(nbr, 6, "model_n2_blkreq_cycles");
        run_queue();
        gap_d[1] = 0;

        build_run(0, -1, 1'b0, 0, 0, 0, 1'b0);
        run_queue();
        chk(t_done - t_start, 25, "n0_done_latency");

        build_run(2, 10, 1'b0, 0, 0, 0, 1'b0);
        run_queue();

        c = blank();
        c.start = 1'b1;
        c.abort = 1'b1;
        c.nperm = 16'd2;
        q.push_back(c);
        m_pcnt = 16'd0;
        push_idle(2, 1'b0);
        run_queue();

`ifdef SHAKE_SCHED_STALL_EN
        build_run(1, -1, 1'b0, 1, 5, 3, 1'b0);
        run_queue();
        chk(t_done - t_start, 28, "stall3_done_latency");
`endif

        for (int r = 0; r < 25; r++) begin
            nreq = $urandom_range(0, 3);
            for (int i = 0; i < 8; i++) gap_d[i] = $urandom_range(0, 3);
`ifdef SHAKE_SCHED_STALL_EN
            build_run(nreq, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 80) : -1,
                      ($urandom_range(0, 2) == 0), $urandom_range(1, 3), $urandom_range(0, R - 1),
                      $urandom_range(0, 3), 1'b1);
`else
            build_run(nreq, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 80) : -1,
                      ($urandom_range(0, 2) == 0), 0, 0, 0, 1'b1);
`endif
            run_queue();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
